// File: rtl/seg_anim_pkg.sv
// Shared FSM state encoding and character-mode constants for the segment animator.
package seg_anim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam logic [1:0] MODE_FWD  = 2'd0;
    localparam logic [1:0] MODE_REV  = 2'd1;
    localparam logic [1:0] MODE_INST = 2'd2;

    // Mode 3 is not a reveal mode, so it falls through to instant handling.
    function automatic logic is_reveal(input logic [1:0] mode);
        return (mode == MODE_FWD) || (mode == MODE_REV);
    endfunction

endpackage

// File: rtl/seg_delay_timer.sv
// Tick-driven down-counter that paces the gap between lit segments.
// Latency: expire is combinational on the enabled tick that finds count==1.
// Backpressure: none; holds its count whenever enable is low.
module seg_delay_timer #(
    parameter int DELAY_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               clear,
    input  logic               load,
    input  logic [DELAY_W-1:0] load_val,
    input  logic               run,
    input  logic               tick,
    output logic               expire
);

    logic [DELAY_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            if (load) begin
                count <= load_val;
            end else if (run && tick && (count != '0)) begin
                count <= count - DELAY_W'(1);
            end
        end
    end

    assign expire = enable && run && tick && !load && (count == DELAY_W'(1));

endmodule

// File: rtl/seg_animator_multi.sv
// Multi-digit seven-segment animator: reveals a character one segment at a time.
// Latency: accept to first lit segment 1 clk; one clk per scanned index plus delay ticks per lit segment.
// Backpressure: char_ready only in IDLE with enable high; offers while busy are dropped, not queued.
module seg_animator_multi
    import seg_anim_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SEG_W      = 7,
    parameter int DELAY_W    = 6,
    localparam int DIG_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    tick,
    input  logic                    flush,
    input  logic                    char_valid,
    output logic                    char_ready,
    input  logic [DIG_W-1:0]        char_digit,
    input  logic [SEG_W-1:0]        char_data,
    input  logic [1:0]              char_mode,
    input  logic [DELAY_W-1:0]      delay,
    output logic [NUM_DIGITS*SEG_W-1:0] seg_out,
    output logic                    busy,
    output logic                    done
);

    localparam int IDX_W = (SEG_W > 1) ? $clog2(SEG_W) : 1;
    localparam int TOT_W = NUM_DIGITS * SEG_W;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic               last, last_nxt;
    logic [TOT_W-1:0]   seg, seg_nxt;
    logic [DIG_W-1:0]   dig_q, dig_nxt;
    logic [SEG_W-1:0]   data_q, data_nxt;
    logic [1:0]         mode_q, mode_nxt;
    logic [DELAY_W-1:0] dly_q, dly_nxt;
    logic               done_nxt;
    logic               alive;
    logic               tmr_load;
    logic               tmr_expire;
    logic               final_idx;
    logic               lit;

    // alive holds char_ready low until the first clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            idx    <= '0;
            last   <= 1'b0;
            seg    <= '0;
            dig_q  <= '0;
            data_q <= '0;
            mode_q <= '0;
            dly_q  <= '0;
            done   <= 1'b0;
            alive  <= 1'b0;
        end else begin
            state  <= state_nxt;
            idx    <= idx_nxt;
            last   <= last_nxt;
            seg    <= seg_nxt;
            dig_q  <= dig_nxt;
            data_q <= data_nxt;
            mode_q <= mode_nxt;
            dly_q  <= dly_nxt;
            // Cleared while frozen so done can never stretch past one cycle.
            done   <= enable ? done_nxt : 1'b0;
            alive  <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        last_nxt  = last;
        seg_nxt   = seg;
        dig_nxt   = dig_q;
        data_nxt  = data_q;
        mode_nxt  = mode_q;
        dly_nxt   = dly_q;
        done_nxt  = 1'b0;
        tmr_load  = 1'b0;
        final_idx = (mode_q == MODE_REV) ? (idx == '0) : (idx == IDX_W'(SEG_W - 1));
        lit       = data_q[idx];

        if (flush) begin
            state_nxt = ST_IDLE;
            idx_nxt   = '0;
            last_nxt  = 1'b0;
            seg_nxt   = '0;
        end else if (enable) begin
            case (state)
                ST_IDLE: begin
                    if (char_valid && alive) begin
                        dig_nxt  = char_digit;
                        data_nxt = char_data;
                        mode_nxt = char_mode;
                        dly_nxt  = delay;
                        // Out-of-range digits match no slot: accepted, display untouched.
                        for (int d = 0; d < NUM_DIGITS; d++) begin
                            if (d == int'(char_digit)) begin
                                seg_nxt[d*SEG_W +: SEG_W] = is_reveal(char_mode) ? '0 : char_data;
                            end
                        end
                        if (is_reveal(char_mode)) begin
                            state_nxt = ST_SCAN;
                            idx_nxt   = (char_mode == MODE_REV) ? IDX_W'(SEG_W - 1) : '0;
                            last_nxt  = 1'b0;
                        end else begin
                            done_nxt = 1'b1;
                        end
                    end
                end
                ST_SCAN: begin
                    if (lit) begin
                        for (int d = 0; d < NUM_DIGITS; d++) begin
                            if (d == int'(dig_q)) begin
                                seg_nxt[d*SEG_W +: SEG_W] = seg[d*SEG_W +: SEG_W] | (SEG_W'(1) << idx);
                            end
                        end
                    end
                    if (!final_idx) begin
                        idx_nxt = (mode_q == MODE_REV) ? idx - IDX_W'(1) : idx + IDX_W'(1);
                    end
                    last_nxt = final_idx;
                    if (lit && (dly_q != '0)) begin
                        tmr_load  = 1'b1;
                        state_nxt = ST_WAIT;
                    end else if (final_idx) begin
                        state_nxt = ST_IDLE;
                        done_nxt  = 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (tmr_expire) begin
                        if (last) begin
                            state_nxt = ST_IDLE;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt = ST_SCAN;
                        end
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    seg_delay_timer #(
        .DELAY_W (DELAY_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .clear    (flush),
        .load     (tmr_load),
        .load_val (dly_q),
        .run      (state == ST_WAIT),
        .tick     (tick),
        .expire   (tmr_expire)
    );

    assign char_ready = enable && alive && (state == ST_IDLE);
    assign busy       = (state != ST_IDLE);
    assign seg_out    = seg;

endmodule

// File: tb/tb_seg_animator_multi.sv
// Scoreboard bench for seg_animator_multi: expected display/done events queued by stimulus, checked by a monitor.
module tb_seg_animator_multi;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        tick;
    logic        flush;
    logic        char_valid;
    logic        char_ready;
    logic [1:0]  char_digit;
    logic [6:0]  char_data;
    logic [1:0]  char_mode;
    logic [5:0]  delay;
    logic [27:0] seg_out;
    logic        busy;
    logic        done;

    typedef struct {
        int          cyc;
        logic [27:0] seg;
        logic        done;
    } ev_t;

    ev_t         exp_q[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [27:0] prev_seg = '0;

    seg_animator_multi #(
        .NUM_DIGITS (4),
        .SEG_W      (7),
        .DELAY_W    (6)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .tick       (tick),
        .flush      (flush),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .char_digit (char_digit),
        .char_data  (char_data),
        .char_mode  (char_mode),
        .delay      (delay),
        .seg_out    (seg_out),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: any change of seg_out or a done pulse is an event to match in order.
    always begin
        @(negedge clk);
        #1;
        if ((seg_out !== prev_seg) || (done === 1'b1)) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event: cyc=%0d seg=%h done=%b, none expected", cyc, seg_out, done);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if ((e.cyc != cyc) || (e.seg !== seg_out) || (e.done !== done)) begin
                    n_fail++;
                    $display("FAIL event: got cyc=%0d seg=%h done=%b, expected cyc=%0d seg=%h done=%b",
                             cyc, seg_out, done, e.cyc, e.seg, e.done);
                end
            end
            prev_seg = seg_out;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic push(input int c, input logic [27:0] s, input logic d);
        ev_t e;
        e.cyc  = c;
        e.seg  = s;
        e.done = d;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [1:0] dig, input logic [6:0] dat, input logic [1:0] md, input logic [5:0] dly);
        check("ready_before_send", {31'd0, char_ready}, 32'd1);
        char_valid = 1'b1;
        char_digit = dig;
        char_data  = dat;
        char_mode  = md;
        delay      = dly;
        @(negedge clk);
        char_valid = 1'b0;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int t;
        logic [27:0] base;

        rst_n      = 1'b0;
        enable     = 1'b1;
        tick       = 1'b0;
        flush      = 1'b0;
        char_valid = 1'b0;
        char_digit = '0;
        char_data  = '0;
        char_mode  = '0;
        delay      = '0;

        #2;
        check("reset_seg", {4'd0, seg_out}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_ready", {31'd0, char_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check("ready_at_release", {31'd0, char_ready}, 32'd0);
        @(negedge clk);
        check("ready_after_release", {31'd0, char_ready}, 32'd1);

        // Forward reveal, digit 1, data 0000101, delay 2.
        a = cyc + 1;
        push(a + 1, 28'h0000080, 1'b0);
        send(2'd1, 7'b0000101, 2'd0, 6'd2);
        step(9);
        pulse_tick();
        step(9);
        t = cyc + 1;
        push(t + 2, 28'h0000280, 1'b0);
        pulse_tick();
        step(9);
        pulse_tick();
        step(9);
        t = cyc + 1;
        push(t + 4, 28'h0000280, 1'b1);
        pulse_tick();
        step(6);
        check("fwd_idle_busy", {31'd0, busy}, 32'd0);

        // Reverse reveal, digit 0, data 1000001, delay 1.
        a = cyc + 1;
        push(a + 1, 28'h00002C0, 1'b0);
        send(2'd0, 7'b1000001, 2'd1, 6'd1);
        step(4);
        t = cyc + 1;
        push(t + 6, 28'h00002C1, 1'b0);
        pulse_tick();
        step(8);
        t = cyc + 1;
        push(t, 28'h00002C1, 1'b1);
        pulse_tick();
        step(3);

        // Instant load of digit 3.
        a = cyc + 1;
        push(a, 28'h0FE002C1, 1'b1);
        send(2'd3, 7'h7F, 2'd2, 6'd9);
        check("inst_busy_0", {31'd0, busy}, 32'd0);
        step(1);
        check("inst_busy_1", {31'd0, busy}, 32'd0);
        step(3);

        // All-zero data: done exactly 7 clk after accept.
        a = cyc + 1;
        push(a + 7, 28'h0FE002C1, 1'b1);
        send(2'd2, 7'h00, 2'd0, 6'd5);
        check("zero_busy", {31'd0, busy}, 32'd1);
        step(9);

        // Full data, delay 0: one segment per clk.
        base = 28'h0FE002C1;
        a = cyc + 1;
        for (int k = 1; k <= 7; k++) begin
            push(a + k, base | (28'((1 << k) - 1) << 14), (k == 7));
        end
        send(2'd2, 7'h7F, 2'd0, 6'd0);
        step(9);

        // Busy offers ignored; enable low mid-WAIT swallows a tick.
        a = cyc + 1;
        push(a, 28'h0FFFC041, 1'b0);
        push(a + 2, 28'h0FFFC141, 1'b0);
        send(2'd1, 7'b0000010, 2'd0, 6'd2);
        char_valid = 1'b1;
        char_digit = 2'd3;
        char_data  = 7'h00;
        char_mode  = 2'd2;
        step(5);
        check("busy_not_ready", {31'd0, char_ready}, 32'd0);
        char_valid = 1'b0;
        pulse_tick();
        step(3);
        enable = 1'b0;
        step(5);
        pulse_tick();
        step(14);
        check("frozen_busy", {31'd0, busy}, 32'd1);
        enable = 1'b1;
        t = cyc + 1;
        push(t + 5, 28'h0FFFC141, 1'b1);
        pulse_tick();
        step(8);

        // Flush mid-SCAN: display cleared, no done.
        a = cyc + 1;
        push(a, 28'h0FFFC100, 1'b0);
        push(a + 1, 28'h0FFFC101, 1'b0);
        push(a + 2, 28'h0FFFC103, 1'b0);
        push(a + 3, 28'h0000000, 1'b0);
        send(2'd0, 7'h7F, 2'd0, 6'd0);
        step(2);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        step(10);
        check("flush_busy", {31'd0, busy}, 32'd0);

        // Asynchronous reset mid-WAIT.
        a = cyc + 1;
        push(a + 1, 28'h0004000, 1'b0);
        send(2'd2, 7'b0000001, 2'd0, 6'd3);
        step(3);
        push(cyc, 28'h0000000, 1'b0);
        rst_n = 1'b0;
        #1;
        check("rst_async_seg", {4'd0, seg_out}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_ready_low", {31'd0, char_ready}, 32'd0);
        @(negedge clk);
        check("rst_ready_back", {31'd0, char_ready}, 32'd1);
        step(10);

        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_events: %0d expected events never seen, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
